// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the unified-memory arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t : bus owner encoding, 00 none / 01 instruction fetch / 10 data
//   DEF_ADDR_W, DEF_DATA_W : default byte-address and word widths
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between instruction fetch and data ports.
// The data port wins a simultaneous request unless the fetch port has been
// starved long enough, in which case the fetch port wins.
//   if_req_i      in  fetch request
//   dm_req_i      in  data request
//   starve_full_i in  fetch port has lost the maximum number of conflicts
//   winner_o      out selected owner (OWN_NONE when nobody requests)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic   if_req_i,
    input  logic   dm_req_i,
    input  logic   starve_full_i,
    output owner_t winner_o
);

    always_comb begin
        winner_o = OWN_NONE;
        if (if_req_i && dm_req_i) begin
            winner_o = starve_full_i ? OWN_IF : OWN_DM;
        end else if (if_req_i) begin
            winner_o = OWN_IF;
        end else if (dm_req_i) begin
            winner_o = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one single-ported
// memory. One transaction at a time: IDLE (grant) -> BUSY (command held until
// mem_ready_i) -> RESP (one-cycle ack to the owner) -> IDLE. All outputs are
// registered.
//   clk_i, rst_i              clock (rising edge), async active-low reset
//   if_req_i, if_addr_i       fetch request / address
//   if_ack_o, if_rdata_o      fetch completion pulse / fetched word
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i     data request / store flag / address / store data
//   dm_ack_o, dm_rdata_o      data completion pulse / load data
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o   memory command, stable for the whole BUSY phase
//   mem_ready_i, mem_rdata_i  memory completion / read data
//   owner_o                   current owner (00 none, 01 IF, 10 DM)
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        owner_o
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t            state_q,     state_d;
    owner_t            owner_q,     owner_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              dm_ack_q,    dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    owner_t            winner;

    mem_arb_pick u_pick (
        .if_req_i      (if_req_i),
        .dm_req_i      (dm_req_i),
        .starve_full_i (starve_cnt_q == STARVE_LIM),
        .winner_o      (winner)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d   = ST_BUSY;
                    owner_d   = winner;
                    mem_req_d = 1'b1;
                    if (winner == OWN_DM) begin
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        mem_we_d    = dm_we_i;
                    end else begin
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_we_d    = 1'b0;
                    end
                    // Any IF grant clears starvation; only a lost conflict counts up.
                    if (winner == OWN_IF) begin
                        starve_cnt_d = '0;
                    end else if (if_req_i && starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready_i) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  owner_o;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_ack_o    (dm_ack_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .owner_o     (owner_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // {mem_req, mem_we, if_ack, dm_ack, owner}
    function automatic logic [5:0] ctl();
        return {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, owner_o};
    endfunction

    task automatic test_reset();
        rst_i = 1'b0;
        if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = '0; dm_wdata_i = '0; mem_ready_i = 0; mem_rdata_i = '0;
        tick(); tick();
        checks++;
        if (ctl() !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 000000", ctl());
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
        end
        rst_i = 1'b1;
    endtask

    // Lone fetch, zero-wait memory; also first grant right after reset release.
    task automatic test_lone_if();
        if_req_i = 1; if_addr_i = 32'h0000_0010;
        mem_ready_i = 1; mem_rdata_i = 32'h0000_0013;
        tick();
        if_req_i = 0;
        checks++;
        if (ctl() !== 6'b1000_01 || mem_addr_o !== 32'h10) begin
            errors++; $display("FAIL if_cycle1 got ctl=%b addr=%h want ctl=100001 addr=00000010", ctl(), mem_addr_o);
        end
        tick();
        checks++;
        if (ctl() !== 6'b0010_01 || if_rdata_o !== 32'h13) begin
            errors++; $display("FAIL if_cycle2_ack got ctl=%b rdata=%h want ctl=001001 rdata=00000013", ctl(), if_rdata_o);
        end
        tick();
        mem_ready_i = 0;
        checks++;
        if (ctl() !== 6'b0 || if_rdata_o !== 32'h13 || dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL if_after got ctl=%b rdata=%h state=%0d want ctl=000000 rdata=00000013 state=0", ctl(), if_rdata_o, dut.state_q);
        end
    endtask

    // Both ports request continuously: DM, DM, then IF once starved.
    task automatic test_starve();
        logic [1:0] exp_own [3];
        logic [1:0] exp_cnt [3];
        exp_own[0] = 2'b10; exp_own[1] = 2'b10; exp_own[2] = 2'b01;
        exp_cnt[0] = 2'd1;  exp_cnt[1] = 2'd2;  exp_cnt[2] = 2'd0;
        if_req_i = 1; if_addr_i = 32'h0000_0020;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h0000_0030;
        mem_ready_i = 1;
        for (int k = 0; k < 3; k++) begin
            mem_rdata_i = 32'hA000_0000 + k;
            tick();
            if (k == 2) begin
                if_req_i = 0; dm_req_i = 0;
            end
            checks++;
            if (owner_o !== exp_own[k] || dut.starve_cnt_q !== exp_cnt[k]) begin
                errors++; $display("FAIL starve_grant%0d got owner=%b cnt=%0d want owner=%b cnt=%0d", k, owner_o, dut.starve_cnt_q, exp_own[k], exp_cnt[k]);
            end
            tick();
            checks++;
            if ({if_ack_o, dm_ack_o} !== {exp_own[k][0], exp_own[k][1]} ||
                (exp_own[k] == 2'b10 && dm_rdata_o !== 32'hA000_0000 + k) ||
                (exp_own[k] == 2'b01 && if_rdata_o !== 32'hA000_0000 + k)) begin
                errors++; $display("FAIL starve_ack%0d got if_ack=%b dm_ack=%b if_rd=%h dm_rd=%h want owner %b acked with %h", k, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, exp_own[k], 32'hA000_0000 + k);
            end
            tick();
        end
        mem_ready_i = 0;
    endtask

    // Store with three wait cycles; requester inputs change after grant.
    task automatic test_store_wait();
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h0000_0100; dm_wdata_i = 32'hDEAD_BEEF;
        mem_ready_i = 0;
        tick();
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = 32'h0000_0200; dm_wdata_i = 32'h1111_2222;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (ctl() !== 6'b1100_10 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL store_cmd_c%0d got ctl=%b addr=%h wdata=%h want ctl=110010 addr=00000100 wdata=deadbeef", c, ctl(), mem_addr_o, mem_wdata_o);
            end
            if (c == 4) begin
                mem_ready_i = 1; mem_rdata_i = 32'hCAFE_0001;
            end
            tick();
        end
        mem_ready_i = 0;
        checks++;
        if (ctl() !== 6'b0001_10 || dm_rdata_o !== 32'hCAFE_0001) begin
            errors++; $display("FAIL store_ack_c5 got ctl=%b rdata=%h want ctl=000110 rdata=cafe0001", ctl(), dm_rdata_o);
        end
        tick();
    endtask

    // Reset pulse mid-BUSY aborts silently; held request is re-granted afresh.
    task automatic test_reset_mid();
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h0000_0040; mem_ready_i = 0;
        tick();
        checks++;
        if (ctl() !== 6'b1000_10) begin
            errors++; $display("FAIL rstmid_busy got ctl=%b want 100010", ctl());
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (ctl() !== 6'b0 || mem_addr_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_async got ctl=%b addr=%h rdata=%h want all 0", ctl(), mem_addr_o, dm_rdata_o);
        end
        mem_ready_i = 1; mem_rdata_i = 32'h0000_0055;
        tick();
        checks++;
        if (ctl() !== 6'b0 || dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL rstmid_held got ctl=%b state=%0d want ctl=000000 state=0", ctl(), dut.state_q);
        end
        rst_i = 1'b1;
        tick();
        dm_req_i = 0;
        checks++;
        if (ctl() !== 6'b1000_10 || mem_addr_o !== 32'h40) begin
            errors++; $display("FAIL rstmid_regrant got ctl=%b addr=%h want ctl=100010 addr=00000040", ctl(), mem_addr_o);
        end
        tick();
        checks++;
        if (ctl() !== 6'b0001_10 || dm_rdata_o !== 32'h55) begin
            errors++; $display("FAIL rstmid_ack got ctl=%b rdata=%h want ctl=000110 rdata=00000055", ctl(), dm_rdata_o);
        end
        tick();
    endtask

    // mem_ready_i pulsing while idle must do nothing.
    task automatic test_spurious_ready();
        mem_ready_i = 1; mem_rdata_i = 32'h0000_0077;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ctl() !== 6'b0 || dut.state_q !== ST_IDLE || dm_rdata_o !== 32'h55 || if_rdata_o !== 32'h0) begin
                errors++; $display("FAIL spurious%0d got ctl=%b state=%0d dm_rd=%h if_rd=%h want ctl=000000 state=0 dm_rd=00000055 if_rd=00000000", c, ctl(), dut.state_q, dm_rdata_o, if_rdata_o);
            end
        end
        mem_ready_i = 0;
    endtask

    initial begin
        test_reset();
        test_lone_if();
        test_starve();
        test_store_wait();
        test_reset_mid();
        test_spurious_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter STARVE_MAX, default 2, consecutive lost conflicts after which the IF port wins.
REQ-004 Ports SHALL be: clk_i  in  1  clock, rising edge; the block has one clock.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 if_req_i  in  1  instruction-fetch request; if_addr_i  in  ADDR_W  fetch address.
REQ-007 if_ack_o  out  1  one-cycle fetch completion; if_rdata_o  out  DATA_W  fetched word, valid while if_ack_o=1.
REQ-008 dm_req_i  in  1  data request; dm_we_i  in  1  1=store, 0=load; dm_addr_i  in  ADDR_W; dm_wdata_i  in  DATA_W.
REQ-009 dm_ack_o  out  1  one-cycle data completion; dm_rdata_o  out  DATA_W  load data, valid while dm_ack_o=1.
REQ-010 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  ADDR_W; mem_wdata_o  out  DATA_W: single-ported unified memory command.
REQ-011 mem_ready_i  in  1  memory completes current command this cycle; mem_rdata_i  in  DATA_W  read data, valid with mem_ready_i.
REQ-012 owner_o  out  2  current owner: 00 none, 01 IF, 10 DM.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, RESP; all outputs registered.
REQ-014 IDLE: with any req high, at the clock edge latch owner, address, we, wdata; go BUSY; else stay IDLE.
REQ-015 Arbitration: DM wins a simultaneous request unless starve_cnt == STARVE_MAX, in which case IF wins.
REQ-016 starve_cnt (width clog2(STARVE_MAX+1)): +1 when IF loses a simultaneous conflict; cleared when IF is granted; saturates at STARVE_MAX.
REQ-017 BUSY: mem_req_o=1 with latched command held stable every cycle; mem_we_o=1 only for DM stores.
REQ-018 BUSY with mem_ready_i=1: capture mem_rdata_i, go RESP; mem_ready_i=0: remain BUSY indefinitely (no timeout).
REQ-019 RESP: exactly one cycle; owner's ack=1 with captured rdata; other ack=0; mem_req_o=0; next state IDLE.
REQ-020 Latency: zero-wait memory gives req sampled at cycle 0, mem_req_o cycle 1, ack cycle 2; each memory wait cycle adds one.
REQ-021 No new grant in BUSY or RESP; a request held through RESP is re-arbitrated in the following IDLE cycle.
REQ-022 Requester changes to addr/wdata/we after grant SHALL be ignored; dropping req before ack SHALL not cancel the transaction.
REQ-023 Store ack: dm_rdata_o SHALL equal mem_rdata_i captured (don't-care to requester but deterministic).
REQ-024 rdata outputs hold last value outside ack cycles; owner_o=00 in IDLE, latched owner in BUSY and RESP.
REQ-025 mem_ready_i outside BUSY SHALL be ignored.

Reset
REQ-026 rst_i=0 asynchronously forces IDLE, starve_cnt=0, all outputs 0, including mid-transaction; the aborted transaction is never acked.
REQ-027 First grant possible on the first rising edge after rst_i deasserts.

Structure
REQ-028 Shared package cpu_pkg holds the FSM state enum, owner encoding (00/01/10), and default ADDR_W/DATA_W.
REQ-029 One combinational sub-module mem_arb_pick (inputs: both reqs, starve flag; output: winner) is natural; the rest is flat.

Verification
REQ-030 Lone IF req addr 0x0000_0010, mem_ready_i=1 immediately, mem_rdata_i=0x0000_0013 -> mem_req_o cycle 1, if_ack_o cycle 2, if_rdata_o=0x13.
REQ-031 Simultaneous IF and DM load on three consecutive arbitrations, STARVE_MAX=2 -> grant order DM, DM, IF; starve_cnt 1, 2, 0.
REQ-032 DM store addr 0x100 wdata 0xDEADBEEF, mem_ready_i low 3 cycles -> mem_we_o=1, command stable 4 cycles, dm_ack_o at cycle 5.
REQ-033 dm_addr_i changed to 0x200 during BUSY -> mem_addr_o stays 0x100.
REQ-034 rst_i pulsed low during BUSY -> outputs 0 immediately, no ack; after release, held req re-granted with full latency.
REQ-035 Spurious mem_ready_i=1 in IDLE, no reqs -> no ack, state stays IDLE.
